// File: rtl/slave_wait_ram_if.sv
// Crossbar slave-side req/ack bus: one request held until a one-cycle ack, read data one cycle later.
// The responder sets latency; the requester holds req and payload stable until ack.
`timescale 1ns/1ps
interface slave_wait_ram_if;
    logic        slave_req;
    logic [31:0] slave_addr;
    logic        slave_cmd;
    logic [31:0] slave_wdata;
    logic        slave_ack;
    logic [31:0] slave_rdata;

    modport master (
        output slave_req, slave_addr, slave_cmd, slave_wdata,
        input  slave_ack, slave_rdata
    );

    modport slave (
        input  slave_req, slave_addr, slave_cmd, slave_wdata,
        output slave_ack, slave_rdata
    );
endinterface

// File: rtl/slave_wait_ram.sv
// Word RAM responder with fixed or LFSR-random wait states; ack at 1+W cycles after req, rdata one cycle later.
// No backpressure of its own: requester holds req until ack, dropping req mid-wait aborts the access.
`timescale 1ns/1ps
module slave_wait_ram #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_MODE   = 0,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [7:0]  WAIT_MASK   = 8'h03,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5,
    parameter logic [31:0] OOR_DATA    = 32'hDEAD_BEEF
) (
    input logic             clk,
    input logic             resetn,
    slave_wait_ram_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t        state_q, state_d;
    logic [7:0]    wcnt_q, wcnt_d;
    logic [7:0]    lfsr_q;
    logic [7:0]    wait_w;
    logic          accept;
    logic [AW-1:0] idx_q;
    logic          oor_q;
    logic          cmd_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          addr_oor;
    logic          unused_addr_bits;
    logic [31:0]   mem [DEPTH];

    // Bit 31 is the crossbar's slave select and bits [1:0] are byte lanes; neither reaches the decode.
    assign addr_oor         = |bus.slave_addr[30:2+AW];
    assign unused_addr_bits = ^{bus.slave_addr[31], bus.slave_addr[1:0]};

    // Random mode samples the LFSR before it advances on the same accept.
    assign wait_w = (WAIT_MODE == 1) ? (lfsr_q & WAIT_MASK) : 8'(WAIT_CYCLES);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.slave_req) begin
                    accept  = 1'b1;
                    wcnt_d  = wait_w;
                    state_d = (wait_w == 8'd0) ? ACK : WAIT;
                end
            end
            WAIT: begin
                if (!bus.slave_req) begin
                    state_d = IDLE;
                    wcnt_d  = 8'd0;
                end else begin
                    wcnt_d = wcnt_q - 8'd1;
                    if (wcnt_q == 8'd1) state_d = ACK;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            wcnt_q  <= 8'd0;
            lfsr_q  <= LFSR_SEED;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            cmd_q   <= 1'b0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (accept) begin
                lfsr_q  <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
                idx_q   <= bus.slave_addr[2 +: AW];
                oor_q   <= addr_oor;
                cmd_q   <= bus.slave_cmd;
                wdata_q <= bus.slave_wdata;
            end
            if (state_q == ACK && !cmd_q) begin
                rdata_q <= oor_q ? OOR_DATA : mem[idx_q];
            end
        end
    end

    // Storage is deliberately unreset; reset only suppresses a write that is still in flight.
    always_ff @(posedge clk) begin
        if (resetn && state_q == ACK && cmd_q && !oor_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.slave_ack   = (state_q == ACK);
    assign bus.slave_rdata = rdata_q;
endmodule
